// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: funct3 access sizes, stage FSM states,
// and lane geometry derived from the datapath width.
package core_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [2:0] {
        S_EMPTY,
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DRAIN
    } state_t;

    function automatic int lane_bytes(int xlen);
        return xlen / 8;
    endfunction

    function automatic int off_bits(int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction
endpackage

// File: rtl/load_align.sv
// Pulls the addressed byte/half/word out of a memory beat and sign- or
// zero-extends it according to the funct3 load size.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]           rdata,
    input  logic [off_bits(XLEN)-1:0] offset,
    input  logic [2:0]                size,
    output logic [XLEN-1:0]           data
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            F3_B:    data = XLEN'($signed(shifted[7:0]));
            F3_H:    data = XLEN'($signed(shifted[15:0]));
            F3_W:    data = XLEN'($signed(shifted[31:0]));
            F3_BU:   data = XLEN'(shifted[7:0]);
            F3_HU:   data = XLEN'(shifted[15:0]);
            F3_WU:   data = XLEN'(shifted[31:0]);
            default: data = shifted;
        endcase
    end
endmodule

// File: rtl/stage_mem_hs.sv
// One-entry memory pipeline stage: holds an execute result, issues at most one
// data-memory request for it, and presents the result to writeback.
module stage_mem_hs
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CSR_AW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                inValid,
    output logic                inReady,
    input  logic [XLEN-1:0]     inAluResult,
    input  logic [XLEN-1:0]     inWriteData,
    input  logic [XLEN-1:0]     inCsrResult,
    input  logic [XLEN-1:0]     inPcPlus4,
    input  logic [REG_AW-1:0]   inRdAddr,
    input  logic [CSR_AW-1:0]   inCsrAddr,
    input  logic [1:0]          inRegSrc,
    input  logic [2:0]          inSize,
    input  logic                inRegWrite,
    input  logic                inCsrWrite,
    input  logic                inMemRead,
    input  logic                inMemWrite,
    output logic                dmemReqValid,
    input  logic                dmemReqReady,
    output logic [XLEN-1:0]     dmemAddr,
    output logic                dmemWen,
    output logic [XLEN/8-1:0]   dmemWstrb,
    output logic [XLEN-1:0]     dmemWdata,
    input  logic                dmemRspValid,
    input  logic [XLEN-1:0]     dmemRdata,
    output logic                outValid,
    input  logic                outReady,
    output logic [XLEN-1:0]     outAluResult,
    output logic [XLEN-1:0]     outReadData,
    output logic [XLEN-1:0]     outCsrResult,
    output logic [XLEN-1:0]     outPcPlus4,
    output logic [REG_AW-1:0]   outRdAddr,
    output logic [CSR_AW-1:0]   outCsrAddr,
    output logic [1:0]          outRegSrc,
    output logic                outRegWrite,
    output logic                outCsrWrite,
    output logic                outMisaligned
);
    localparam int NB   = lane_bytes(XLEN);
    localparam int OFFW = off_bits(XLEN);

    state_t          state;
    logic [2:0]      size_q;
    logic            mem_read_q;
    logic [OFFW-1:0] in_off;
    logic            mem_op, mis_off, misaligned, accept;
    logic [NB-1:0]   strb_base, strb;
    logic [XLEN-1:0] wdata, load_data;

    assign inReady = (state == S_EMPTY) || (state == S_FULL && outReady);
    assign accept  = inValid && inReady && !flush;
    assign in_off  = inAluResult[OFFW-1:0];
    assign mem_op  = inMemRead || inMemWrite;

    always_comb begin
        mis_off   = 1'b0;
        strb_base = '1;
        wdata     = inWriteData;
        case (inSize[1:0])
            2'd0: begin
                strb_base = NB'(1);
                wdata     = {NB{inWriteData[7:0]}};
            end
            2'd1: begin
                mis_off   = in_off[0];
                strb_base = NB'(3);
                wdata     = {(NB/2){inWriteData[15:0]}};
            end
            2'd2: begin
                mis_off   = (in_off[1:0] != 2'd0);
                strb_base = NB'(15);
                wdata     = {(NB/4){inWriteData[31:0]}};
            end
            default: mis_off = (in_off != '0);
        endcase
        misaligned = mem_op && mis_off;
        strb       = inMemWrite ? (strb_base << in_off) : '0;
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmemRdata),
        .offset (dmemAddr[OFFW-1:0]),
        .size   (size_q),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_EMPTY;
            size_q        <= '0;
            mem_read_q    <= 1'b0;
            dmemReqValid  <= 1'b0;
            dmemAddr      <= '0;
            dmemWen       <= 1'b0;
            dmemWstrb     <= '0;
            dmemWdata     <= '0;
            outValid      <= 1'b0;
            outAluResult  <= '0;
            outReadData   <= '0;
            outCsrResult  <= '0;
            outPcPlus4    <= '0;
            outRdAddr     <= '0;
            outCsrAddr    <= '0;
            outRegSrc     <= '0;
            outRegWrite   <= 1'b0;
            outCsrWrite   <= 1'b0;
            outMisaligned <= 1'b0;
        end else if (flush) begin
            // A request already handed to memory still owes a response; swallow it.
            if (state == S_WAIT || (state == S_REQ && dmemReqReady))
                state <= S_DRAIN;
            else
                state <= S_EMPTY;
            dmemReqValid <= 1'b0;
            outValid     <= 1'b0;
        end else begin
            case (state)
                S_REQ: if (dmemReqReady) begin
                    dmemReqValid <= 1'b0;
                    state        <= S_WAIT;
                end
                S_WAIT: if (dmemRspValid) begin
                    if (mem_read_q) outReadData <= load_data;
                    outValid <= 1'b1;
                    state    <= S_FULL;
                end
                S_FULL: if (outReady) begin
                    outValid <= 1'b0;
                    state    <= S_EMPTY;
                end
                S_DRAIN: if (dmemRspValid) state <= S_EMPTY;
                default: ;
            endcase
            // Accept overrides the FULL->EMPTY retire so back-to-back ops stream.
            if (accept) begin
                size_q        <= inSize;
                mem_read_q    <= inMemRead;
                dmemAddr      <= inAluResult;
                dmemWen       <= inMemWrite;
                dmemWstrb     <= strb;
                dmemWdata     <= wdata;
                outAluResult  <= inAluResult;
                outReadData   <= '0;
                outCsrResult  <= inCsrResult;
                outPcPlus4    <= inPcPlus4;
                outRdAddr     <= inRdAddr;
                outCsrAddr    <= inCsrAddr;
                outRegSrc     <= inRegSrc;
                outRegWrite   <= inRegWrite && !misaligned;
                outCsrWrite   <= inCsrWrite && !misaligned;
                outMisaligned <= misaligned;
                if (mem_op && !misaligned) begin
                    dmemReqValid <= 1'b1;
                    outValid     <= 1'b0;
                    state        <= S_REQ;
                end else begin
                    dmemReqValid <= 1'b0;
                    outValid     <= 1'b1;
                    state        <= S_FULL;
                end
            end
        end
    end
endmodule

// File: tb/tb_stage_mem_hs.sv
// Randomized transaction-level bench for stage_mem_hs (XLEN=32) with directed
// flush/reset scenarios; expectations come from a byte-lane arithmetic model.
module tb_stage_mem_hs;
    logic        clk, rst, flush, inValid, inReady;
    logic [31:0] inAluResult, inWriteData, inCsrResult, inPcPlus4;
    logic [4:0]  inRdAddr;
    logic [11:0] inCsrAddr;
    logic [1:0]  inRegSrc;
    logic [2:0]  inSize;
    logic        inRegWrite, inCsrWrite, inMemRead, inMemWrite;
    logic        dmemReqValid, dmemReqReady, dmemWen, dmemRspValid;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata;
    logic [3:0]  dmemWstrb;
    logic        outValid, outReady, outRegWrite, outCsrWrite, outMisaligned;
    logic [31:0] outAluResult, outReadData, outCsrResult, outPcPlus4;
    logic [4:0]  outRdAddr;
    logic [11:0] outCsrAddr;
    logic [1:0]  outRegSrc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] seen_rd, seen_wdata;
    logic [3:0]  seen_strb;

    stage_mem_hs #(.XLEN(32), .REG_AW(5), .CSR_AW(12)) dut (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
        .inAluResult(inAluResult), .inWriteData(inWriteData), .inCsrResult(inCsrResult),
        .inPcPlus4(inPcPlus4), .inRdAddr(inRdAddr), .inCsrAddr(inCsrAddr),
        .inRegSrc(inRegSrc), .inSize(inSize), .inRegWrite(inRegWrite),
        .inCsrWrite(inCsrWrite), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
        .dmemReqValid(dmemReqValid), .dmemReqReady(dmemReqReady), .dmemAddr(dmemAddr),
        .dmemWen(dmemWen), .dmemWstrb(dmemWstrb), .dmemWdata(dmemWdata),
        .dmemRspValid(dmemRspValid), .dmemRdata(dmemRdata), .outValid(outValid),
        .outReady(outReady), .outAluResult(outAluResult), .outReadData(outReadData),
        .outCsrResult(outCsrResult), .outPcPlus4(outPcPlus4), .outRdAddr(outRdAddr),
        .outCsrAddr(outCsrAddr), .outRegSrc(outRegSrc), .outRegWrite(outRegWrite),
        .outCsrWrite(outCsrWrite), .outMisaligned(outMisaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: byte-lane arithmetic on the 32-bit word.
    function automatic logic [31:0] exp_load(logic [31:0] rd, logic [31:0] a, logic [2:0] f3);
        int nb = 1 << f3[1:0];
        logic [31:0] v, m;
        v = rd >> (8 * (a % 4));
        m = (nb == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 32'h1;
        v = v & m;
        if (!f3[2] && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [3:0] exp_strb(logic [31:0] a, logic [2:0] f3);
        int nb = 1 << f3[1:0];
        logic [3:0] m;
        m = (nb == 4) ? 4'hF : (4'h1 << nb) - 4'h1;
        return m << (a % 4);
    endfunction

    function automatic logic [31:0] exp_wdata(logic [31:0] wd, logic [2:0] f3);
        case (f3[1:0])
            2'd0:    return {24'h0, wd[7:0]} * 32'h0101_0101;
            2'd1:    return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    task automatic drive_in(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic rw);
        inAluResult = addr;
        inWriteData = wd;
        inCsrResult = ~addr;
        inPcPlus4   = addr + 32'd4;
        inRdAddr    = addr[6:2];
        inCsrAddr   = addr[11:0] ^ 12'hA5A;
        inRegSrc    = 2'(kind);
        inSize      = f3;
        inMemRead   = (kind == 1);
        inMemWrite  = (kind == 2);
        inRegWrite  = rw;
        inCsrWrite  = rw;
    endtask

    // kind: 0 ALU, 1 load, 2 store. Starts and ends at a negedge with the stage empty.
    task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int req_lat, input int rsp_lat, input int stall, input logic rw);
        int  nb    = 1 << f3[1:0];
        bit  memop = (kind != 0);
        bit  mis   = memop && ((addr % nb) != 0);
        int  t     = 0;
        drive_in(kind, f3, addr, wd, rw);
        inValid = 1'b1;
        while (!inReady && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("in_ready_idle", inReady, 1'b1);
        @(negedge clk);
        inValid = 1'b0;
        if (memop && !mis) begin
            check("req_valid", dmemReqValid, 1'b1);
            check("outvalid_in_req", outValid, 1'b0);
            check("req_addr", dmemAddr, addr);
            check("req_wen", dmemWen, kind == 2);
            check("req_strb", dmemWstrb, (kind == 2) ? exp_strb(addr, f3) : 4'h0);
            if (kind == 2) check("req_wdata", dmemWdata, exp_wdata(wd, f3));
            seen_strb  = dmemWstrb;
            seen_wdata = dmemWdata;
            repeat (req_lat) begin
                @(negedge clk);
                check("req_hold_valid", dmemReqValid, 1'b1);
                check("req_hold_addr", dmemAddr, addr);
            end
            dmemReqReady = 1'b1;
            @(negedge clk);
            dmemReqReady = 1'b0;
            check("req_dropped", dmemReqValid, 1'b0);
            repeat (rsp_lat) begin
                check("wait_no_out", outValid, 1'b0);
                @(negedge clk);
            end
            dmemRspValid = 1'b1;
            dmemRdata    = rd;
            @(negedge clk);
            dmemRspValid = 1'b0;
            dmemRdata    = $urandom;
        end else begin
            check("no_req", dmemReqValid, 1'b0);
        end
        check("out_valid", outValid, 1'b1);
        outReady = 1'b0;
        repeat (stall) begin
            check("stall_valid", outValid, 1'b1);
            check("stall_inready", inReady, 1'b0);
            check("stall_alu", outAluResult, addr);
            @(negedge clk);
        end
        outReady = 1'b1;
        #1;
        check("full_inready", inReady, 1'b1);
        check("out_alu", outAluResult, addr);
        check("out_pc4", outPcPlus4, addr + 32'd4);
        check("out_rd", outRdAddr, addr[6:2]);
        check("out_mis", outMisaligned, mis);
        check("out_regwrite", outRegWrite, rw && !mis);
        check("out_csrwrite", outCsrWrite, rw && !mis);
        if (kind == 1 && !mis) check("out_rdata", outReadData, exp_load(rd, addr, f3));
        seen_rd = outReadData;
        @(negedge clk);
        outReady = 1'b0;
        check("retired", outValid, 1'b0);
    endtask

    // Accept a load and complete its request handshake, leaving the stage in WAIT.
    task automatic load_to_wait(input logic [31:0] addr);
        drive_in(1, 3'd2, addr, 32'h0, 1'b1);
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        check("ltw_req", dmemReqValid, 1'b1);
        dmemReqReady = 1'b1;
        @(negedge clk);
        dmemReqReady = 1'b0;
    endtask

    initial begin
        logic [2:0] ld_sizes [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        dmemReqReady = 1'b0; dmemRspValid = 1'b0; dmemRdata = '0;
        drive_in(0, 3'd0, 32'h0, 32'h0, 1'b0);
        #12;
        check("rst_outvalid", outValid, 1'b0);
        check("rst_reqvalid", dmemReqValid, 1'b0);
        check("rst_wen", dmemWen, 1'b0);
        check("rst_strb", dmemWstrb, 4'h0);
        check("rst_alu", outAluResult, 32'h0);
        check("rst_mis", outMisaligned, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_inready", inReady, 1'b1);

        // Directed scenarios with literal expectations.
        run_txn(0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, 0, 0, 1'b1);
        check("alu_1234", outAluResult, 32'h1234);
        run_txn(2, 3'd0, 32'h1003, 32'hAB, 32'h0, 1, 1, 0, 1'b0);
        check("sb_strb", seen_strb, 4'b1000);
        check("sb_wdata", seen_wdata, 32'hABAB_ABAB);
        run_txn(1, 3'd0, 32'h2001, 32'h0, 32'h0000_F100, 0, 3, 0, 1'b1);
        check("lb_sext", seen_rd, 32'hFFFF_FFF1);
        run_txn(1, 3'd4, 32'h2001, 32'h0, 32'h0000_F100, 0, 3, 0, 1'b1);
        check("lbu_zext", seen_rd, 32'h0000_00F1);
        run_txn(1, 3'd2, 32'h2002, 32'h0, 32'h0, 0, 0, 0, 1'b1);
        run_txn(0, 3'd0, 32'h5A5A, 32'h0, 32'h0, 0, 0, 4, 1'b1);

        // Flush while waiting for the response: the late response is swallowed.
        load_to_wait(32'h3000);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fw_outvalid", outValid, 1'b0);
        check("fw_inready0", inReady, 1'b0);
        @(negedge clk);
        check("fw_inready1", inReady, 1'b0);
        dmemRspValid = 1'b1;
        @(negedge clk);
        dmemRspValid = 1'b0;
        check("fw_inready_after", inReady, 1'b1);
        check("fw_outvalid_after", outValid, 1'b0);

        // Flush coinciding with the request handshake also drains.
        drive_in(2, 3'd2, 32'h4000, 32'h1, 1'b0);
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        dmemReqReady = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        dmemReqReady = 1'b0;
        flush = 1'b0;
        check("fr_drain_inready", inReady, 1'b0);
        dmemRspValid = 1'b1;
        @(negedge clk);
        dmemRspValid = 1'b0;
        check("fr_empty_inready", inReady, 1'b1);

        // Flush beats a same-cycle accept.
        drive_in(0, 3'd0, 32'h77, 32'h0, 1'b1);
        inValid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        flush = 1'b0;
        check("fa_outvalid", outValid, 1'b0);
        check("fa_reqvalid", dmemReqValid, 1'b0);

        // Reset during a writeback stall clears outValid immediately.
        drive_in(0, 3'd0, 32'h9999, 32'h0, 1'b1);
        inValid = 1'b1;
        @(negedge clk);
        inValid = 1'b0;
        repeat (4) begin
            check("rs_valid", outValid, 1'b1);
            check("rs_inready", inReady, 1'b0);
            check("rs_alu", outAluResult, 32'h9999);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("rs_async_clear", outValid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset during WAIT abandons the request; the late response is ignored.
        load_to_wait(32'h5000);
        rst = 1'b0;
        #1;
        check("rw_reqvalid", dmemReqValid, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        dmemRspValid = 1'b1;
        @(negedge clk);
        dmemRspValid = 1'b0;
        check("rw_outvalid", outValid, 1'b0);
        check("rw_inready", inReady, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            int          kind = $urandom_range(0, 2);
            logic [2:0]  f3;
            logic [31:0] addr = $urandom;
            f3 = (kind == 1) ? ld_sizes[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'h1 << f3[1:0]) - 32'h1);
            run_txn(kind, f3, addr, $urandom, $urandom, $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
